ring_l1a_addr_ctrl: RTL and testbench

- Upstream companion of the ring-to-event-buffer transfer FSM; owns the sample-ring write pointer and the L1A address queue.
- On each L1A it captures the ring sample address of the triggered event (write pointer minus programmable latency) into a small FIFO, and drives L1A_BUF_MT and RING_AMT into the transfer FSM.
- On the transfer FSM's LD_ADDR, SAMP_ADV and NXT_L1A strobes it supplies and advances the ring read sample address, then retires the L1A entry.

---
 rtl/ring_l1a_addr_ctrl_if.sv | 17 +
 rtl/ring_l1a_addr_ctrl.sv | 80 ++++++++
 tb/tb_ring_l1a_addr_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/ring_l1a_addr_ctrl_if.sv
// ring_l1a_addr_ctrl_if: strobes from the trigger/transfer side and ring/queue status back to it
interface ring_l1a_addr_ctrl_if #(
  parameter int AW = 7
);
  logic          SAMP_WE, L1A, LD_ADDR, SAMP_ADV, NXT_L1A;
  logic [AW-1:0] L1A_DLY, WR_SAMP_ADDR, RD_SAMP_ADDR;
  logic          L1A_BUF_MT, L1A_BUF_FULL, RING_AMT, RING_OVR;
  logic [7:0]    L1A_OVF_CNT;
  modport master (
    output SAMP_WE, L1A, L1A_DLY, LD_ADDR, SAMP_ADV, NXT_L1A,
    input  WR_SAMP_ADDR, RD_SAMP_ADDR, L1A_BUF_MT, L1A_BUF_FULL, RING_AMT, RING_OVR, L1A_OVF_CNT
  );
  modport slave (
    input  SAMP_WE, L1A, L1A_DLY, LD_ADDR, SAMP_ADV, NXT_L1A,
    output WR_SAMP_ADDR, RD_SAMP_ADDR, L1A_BUF_MT, L1A_BUF_FULL, RING_AMT, RING_OVR, L1A_OVF_CNT
  );
endinterface

// File: rtl/ring_l1a_addr_ctrl.sv
// ring_l1a_addr_ctrl: ring write pointer, L1A address FIFO and read-sample sequencer
module ring_l1a_addr_ctrl #(
  parameter int AW = 7,
  parameter int QW = 4,
  parameter int AMT_THRESH = 1
) (
  input logic CLK,
  input logic RST,
  ring_l1a_addr_ctrl_if.slave bus
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  localparam logic [QW:0] DEPTH = (QW+1)'(2**QW);
  state_t        state_q, state_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, nxt, avail;
  logic [AW-1:0] mem [2**QW];
  logic [QW-1:0] head_q, tail_q;
  logic [QW:0]   cnt_q, cnt_d;
  logic          first_q, first_d, mt_q, full_q, amt_q, ovr_q, push, pop;
  logic [7:0]    ovf_q;
  // a pop frees a slot in the same cycle, so a full FIFO still accepts a coincident L1A
  assign pop   = bus.NXT_L1A && cnt_q != '0;
  assign push  = bus.L1A && (cnt_q != DEPTH || pop);
  assign wr_d  = wr_q + AW'(bus.SAMP_WE);
  assign cnt_d = cnt_q + (QW+1)'(push) - (QW+1)'(pop);
  assign nxt   = first_q ? rd_q : rd_q + AW'(1);
  assign avail = wr_q - nxt;
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    first_d = first_q;
    if (bus.NXT_L1A) begin
      state_d = IDLE;
      first_d = 1'b0;
    end else if (bus.LD_ADDR && cnt_q != '0) begin
      state_d = ACTIVE;
      rd_d    = mem[head_q];
      first_d = 1'b1;
    end else if (bus.SAMP_ADV && state_q == ACTIVE) begin
      first_d = 1'b0;
      rd_d    = first_q ? rd_q : rd_q + AW'(1);
    end
  end
  always_ff @(posedge CLK)
    if (push) mem[tail_q] <= wr_q - bus.L1A_DLY;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      first_q <= 1'b0;
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      mt_q    <= 1'b1;
      full_q  <= 1'b0;
      amt_q   <= 1'b1;
      ovr_q   <= 1'b0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
      head_q  <= head_q + QW'(pop);
      tail_q  <= tail_q + QW'(push);
      mt_q    <= cnt_d == '0;
      full_q  <= cnt_d == DEPTH;
      amt_q   <= state_q == IDLE || avail < AW'(AMT_THRESH);
      ovr_q   <= ovr_q || (bus.SAMP_WE && state_q == ACTIVE && wr_q + AW'(1) == rd_q);
      if (bus.L1A && !push && ovf_q != 8'hff) ovf_q <= ovf_q + 8'd1;
    end
  assign bus.WR_SAMP_ADDR = wr_q;
  assign bus.RD_SAMP_ADDR = rd_q;
  assign bus.L1A_BUF_MT   = mt_q;
  assign bus.L1A_BUF_FULL = full_q;
  assign bus.RING_AMT     = amt_q;
  assign bus.RING_OVR     = ovr_q;
  assign bus.L1A_OVF_CNT  = ovf_q;
endmodule

// File: tb/tb_ring_l1a_addr_ctrl.sv
// tb_ring_l1a_addr_ctrl: directed vector table with hand-computed expectations plus an async reset sequence
module tb_ring_l1a_addr_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   nvec = 0;
  int   nmis = 0;
  always #5 CLK = ~CLK;
  ring_l1a_addr_ctrl_if #(.AW(7)) bus ();
  ring_l1a_addr_ctrl #(.AW(7), .QW(4), .AMT_THRESH(1)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  typedef struct {
    string       name;
    bit          pre_rst;
    int          n;
    logic        we, l1a, ld, adv, nxt;
    logic [6:0]  dly;
    logic [25:0] exp;
  } vec_t;
  vec_t tbl[$];
  localparam logic [25:0] RST_EXP = {7'd0, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
  function automatic void add(string nm, bit pr, int n, logic we, logic l1a, int dly, logic ld,
                              logic adv, logic nxt, int wr, int rd, logic mt, logic full,
                              logic amt, logic ovr, int ovf);
    vec_t v;
    v.name = nm; v.pre_rst = pr; v.n = n;
    v.we = we; v.l1a = l1a; v.dly = 7'(dly); v.ld = ld; v.adv = adv; v.nxt = nxt;
    v.exp = {7'(wr), 7'(rd), mt, full, amt, ovr, 8'(ovf)};
    tbl.push_back(v);
  endfunction
  task automatic drive(logic we, logic l1a, logic [6:0] dly, logic ld, logic adv, logic nxt);
    bus.SAMP_WE = we; bus.L1A = l1a; bus.L1A_DLY = dly;
    bus.LD_ADDR = ld; bus.SAMP_ADV = adv; bus.NXT_L1A = nxt;
  endtask
  task automatic check(string nm, logic [25:0] e);
    logic [25:0] a;
    a = {bus.WR_SAMP_ADDR, bus.RD_SAMP_ADDR, bus.L1A_BUF_MT, bus.L1A_BUF_FULL,
         bus.RING_AMT, bus.RING_OVR, bus.L1A_OVF_CNT};
    nvec++;
    if (a !== e) begin
      nmis++;
      $display("FAIL %s: got wr=%0d rd=%0d mt=%b full=%b amt=%b ovr=%b ovf=%0d, expected wr=%0d rd=%0d mt=%b full=%b amt=%b ovr=%b ovf=%0d",
               nm, a[25:19], a[18:12], a[11], a[10], a[9], a[8], a[7:0],
               e[25:19], e[18:12], e[11], e[10], e[9], e[8], e[7:0]);
    end
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0);
    //   name           rst  n   we l1a dly ld adv nxt  wr   rd  mt fu amt ovr ovf
    add("we_x10",       0, 10,  1, 0,  4,  0, 0, 0,   10,  0,  1, 0, 1, 0, 0);
    add("l1a_dly4",     0,  1,  0, 1,  4,  0, 0, 0,   10,  0,  0, 0, 1, 0, 0);
    add("ld_rd6",       0,  1,  0, 0,  4,  1, 0, 0,   10,  6,  0, 0, 1, 0, 0);
    add("amt_lag",      0,  1,  0, 0,  4,  0, 0, 0,   10,  6,  0, 0, 0, 0, 0);
    add("adv_first",    0,  1,  0, 0,  4,  0, 1, 0,   10,  6,  0, 0, 0, 0, 0);
    add("adv_7",        0,  1,  0, 0,  4,  0, 1, 0,   10,  7,  0, 0, 0, 0, 0);
    add("adv_8",        0,  1,  0, 0,  4,  0, 1, 0,   10,  8,  0, 0, 0, 0, 0);
    add("adv_9",        0,  1,  0, 0,  4,  0, 1, 0,   10,  9,  0, 0, 0, 0, 0);
    add("amt_caught",   0,  1,  0, 0,  4,  0, 0, 0,   10,  9,  0, 0, 1, 0, 0);
    add("we_lag",       0,  1,  1, 0,  4,  0, 0, 0,   11,  9,  0, 0, 1, 0, 0);
    add("amt_release",  0,  1,  0, 0,  4,  0, 0, 0,   11,  9,  0, 0, 0, 0, 0);
    add("nxt_pop",      0,  1,  0, 0,  4,  0, 0, 1,   11,  9,  1, 0, 0, 0, 0);
    add("idle_amt",     0,  1,  0, 0,  4,  0, 0, 0,   11,  9,  1, 0, 1, 0, 0);
    add("ld_empty",     0,  1,  0, 0,  4,  1, 0, 0,   11,  9,  1, 0, 1, 0, 0);
    add("nxt_empty",    0,  1,  0, 0,  4,  0, 0, 1,   11,  9,  1, 0, 1, 0, 0);
    add("we_to_3",      0,120,  1, 0,  5,  0, 0, 0,    3,  9,  1, 0, 1, 0, 0);
    add("l1a_dly5",     0,  1,  0, 1,  5,  0, 0, 0,    3,  9,  0, 0, 1, 0, 0);
    add("ld_rd126",     0,  1,  0, 0,  5,  1, 0, 0,    3,126,  0, 0, 1, 0, 0);
    add("adv_first_w",  0,  1,  0, 0,  5,  0, 1, 0,    3,126,  0, 0, 0, 0, 0);
    add("adv_127",      0,  1,  0, 0,  5,  0, 1, 0,    3,127,  0, 0, 0, 0, 0);
    add("adv_wrap0",    0,  1,  0, 0,  5,  0, 1, 0,    3,  0,  0, 0, 0, 0, 0);
    add("we_and_adv",   0,  1,  1, 0,  5,  0, 1, 0,    4,  1,  0, 0, 0, 0, 0);
    add("nxt_pop_w",    0,  1,  0, 0,  5,  0, 0, 1,    4,  1,  1, 0, 0, 0, 0);
    add("idle_w",       0,  1,  0, 0,  5,  0, 0, 0,    4,  1,  1, 0, 1, 0, 0);
    add("fill_16",      0, 16,  1, 1,  0,  0, 0, 0,   20,  1,  0, 1, 1, 0, 0);
    add("l1a_drop",     0,  1,  0, 1,  0,  0, 0, 0,   20,  1,  0, 1, 1, 0, 1);
    add("l1a_pop_full", 0,  1,  0, 1,  0,  0, 0, 1,   20,  1,  0, 1, 1, 0, 1);
    add("drain_15",     0, 15,  0, 0,  0,  0, 0, 1,   20,  1,  0, 0, 1, 0, 1);
    add("ld_18th",      0,  1,  0, 0,  0,  1, 0, 0,   20, 20,  0, 0, 1, 0, 1);
    add("dly0_hold",    0,  1,  0, 0,  0,  0, 0, 0,   20, 20,  0, 0, 1, 0, 1);
    add("dly0_we",      0,  1,  1, 0,  0,  0, 0, 0,   21, 20,  0, 0, 1, 0, 1);
    add("dly0_ready",   0,  1,  0, 0,  0,  0, 0, 0,   21, 20,  0, 0, 0, 0, 1);
    add("we_x126",      0,126,  1, 0,  0,  0, 0, 0,   19, 20,  0, 0, 0, 0, 1);
    add("ovr_set",      0,  1,  1, 0,  0,  0, 0, 0,   20, 20,  0, 0, 0, 1, 1);
    add("ovr_sticky",   0,  5,  1, 0,  0,  0, 0, 0,   25, 20,  0, 0, 0, 1, 1);
    add("ovr_nxt",      0,  1,  0, 0,  0,  0, 0, 1,   25, 20,  1, 0, 0, 1, 1);
    add("ovr_idle",     0,  1,  0, 0,  0,  0, 0, 0,   25, 20,  1, 0, 1, 1, 1);
    add("queue_3",      0,  3,  0, 1,  0,  0, 0, 0,   25, 20,  0, 0, 1, 1, 1);
    add("ld_rd25",      0,  1,  0, 0,  0,  1, 0, 0,   25, 25,  0, 0, 1, 1, 1);
    add("rst_l1a",      1,  1,  0, 1,  3,  0, 0, 0,    0,  0,  0, 0, 1, 0, 0);
    add("rst_ld",       0,  1,  0, 0,  3,  1, 0, 0,    0,125,  0, 0, 1, 0, 0);
    add("rst_nxt",      0,  1,  0, 0,  3,  0, 0, 1,    0,125,  1, 0, 0, 0, 0);
    #12 check("reset_state", RST_EXP);
    #1 RST = 1'b0;
    @(posedge CLK);
    #1;
    foreach (tbl[i]) begin
      if (tbl[i].pre_rst) begin
        drive(0, 0, 0, 0, 0, 0);
        #1 RST = 1'b1;
        #1 check("async_rst", RST_EXP);
        #1 RST = 1'b0;
      end
      for (int k = 0; k < tbl[i].n; k++) begin
        drive(tbl[i].we, tbl[i].l1a, tbl[i].dly, tbl[i].ld, tbl[i].adv, tbl[i].nxt);
        @(posedge CLK);
        #1;
      end
      check(tbl[i].name, tbl[i].exp);
    end
    drive(0, 0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
